// File: rtl/fibonacci_seq_gen.sv
// Fibonacci sequence generator.
// Walks F(0)..F(n) one term per step. In result mode (mode=0) it steps every
// cycle and reports F(n). In stream mode (mode=1) it presents each term on a
// valid/ready stream and steps only when the consumer accepts a term.
// The overflow output is true when the real (unwrapped) F(n) does not fit in
// WIDTH bits.
module fibonacci_seq_gen #(
   parameter int WIDTH = 16,
   parameter int NW    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [NW-1:0]    n,
   input  logic             mode,
   input  logic             abort,
   input  logic             out_ready,
   output logic             busy,
   output logic [WIDTH-1:0] term,
   output logic [NW-1:0]    term_idx,
   output logic             term_valid,
   output logic [WIDTH-1:0] fib,
   output logic             overflow,
   output logic             done
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           state_reg;
   logic [NW-1:0]    n_reg;
   logic             mode_reg;
   logic [NW-1:0]    k_reg;
   logic [WIDTH-1:0] cur_reg;
   logic [WIDTH-1:0] nxt_reg;
   logic             cur_ovf_reg;   // true F(k)   >= 2^WIDTH
   logic             nxt_ovf_reg;   // true F(k+1) >= 2^WIDTH
   logic [WIDTH-1:0] fib_reg;
   logic             overflow_reg;
   logic             done_reg;

   logic [WIDTH:0]   sum;
   logic             step;

   // Next-term sum with carry, and the condition that advances the sequence.
   // In stream mode a step is a completed transfer; term_valid is implied
   // because the step is only consulted while in RUN.
   always_comb begin
      sum  = {1'b0, cur_reg} + {1'b0, nxt_reg};
      step = mode_reg ? out_ready : 1'b1;
   end

   // Control FSM plus the term/overflow datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= S_IDLE;
         n_reg        <= '0;
         mode_reg     <= 1'b0;
         k_reg        <= '0;
         cur_reg      <= '0;
         nxt_reg      <= {{(WIDTH-1){1'b0}}, 1'b1};
         cur_ovf_reg  <= 1'b0;
         nxt_ovf_reg  <= 1'b0;
         fib_reg      <= '0;
         overflow_reg <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               // abort beats a simultaneous start
               if (start && !abort) begin
                  n_reg       <= n;
                  mode_reg    <= mode;
                  k_reg       <= '0;
                  cur_reg     <= '0;
                  nxt_reg     <= {{(WIDTH-1){1'b0}}, 1'b1};
                  cur_ovf_reg <= 1'b0;
                  nxt_ovf_reg <= 1'b0;
                  state_reg   <= S_RUN;
               end
            end
            S_RUN: begin
               if (abort) begin
                  state_reg <= S_IDLE;
               end else if (step) begin
                  if (k_reg == n_reg) begin
                     fib_reg      <= cur_reg;
                     overflow_reg <= cur_ovf_reg;
                     done_reg     <= 1'b1;
                     state_reg    <= S_IDLE;
                  end else begin
                     k_reg       <= k_reg + 1'b1;
                     cur_reg     <= nxt_reg;
                     nxt_reg     <= sum[WIDTH-1:0];
                     cur_ovf_reg <= nxt_ovf_reg;
                     // The real sum overflows if either addend already did or
                     // the wrapped addition carries out.
                     nxt_ovf_reg <= nxt_ovf_reg | cur_ovf_reg | sum[WIDTH];
                  end
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign busy       = (state_reg == S_RUN);
   assign term_valid = (state_reg == S_RUN) && mode_reg;
   assign term       = cur_reg;
   assign term_idx   = k_reg;
   assign fib        = fib_reg;
   assign overflow   = overflow_reg;
   assign done       = done_reg;

endmodule

// File: tb/tb_fibonacci_seq_gen.sv
// Bench for fibonacci_seq_gen (WIDTH=8, NW=8).
// Expected results and stream terms are queued when a run is started; a
// monitor on the falling edge pops and compares them whenever done or a
// stream transfer appears.
module tb_fibonacci_seq_gen;

   localparam int WIDTH = 8;
   localparam int NW    = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [NW-1:0]    n_in = '0;
   logic             mode_in = 1'b0;
   logic             abort = 1'b0;
   logic             out_ready = 1'b0;
   logic             busy;
   logic [WIDTH-1:0] term;
   logic [NW-1:0]    term_idx;
   logic             term_valid;
   logic [WIDTH-1:0] fib;
   logic             overflow;
   logic             done;

   int n_cmp = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [WIDTH-1:0] val;
      logic             flag;
   } res_t;

   typedef struct packed {
      logic [WIDTH-1:0] val;
      logic [NW-1:0]    idx;
   } trm_t;

   res_t res_q[$];
   trm_t trm_q[$];

   fibonacci_seq_gen #(.WIDTH(WIDTH), .NW(NW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .n(n_in), .mode(mode_in),
      .abort(abort), .out_ready(out_ready), .busy(busy), .term(term),
      .term_idx(term_idx), .term_valid(term_valid), .fib(fib),
      .overflow(overflow), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: result scoreboard, stream scoreboard, stall stability.
   logic             stalled_prev = 1'b0;
   logic [WIDTH-1:0] prev_term;
   logic [NW-1:0]    prev_idx;

   always @(negedge clk) begin
      if (!rst_n) begin
         stalled_prev = 1'b0;
      end else begin
         if (done) begin
            if (res_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               res_t r;
               r = res_q.pop_front();
               check("fib", int'(fib), int'(r.val));
               check("overflow", int'(overflow), int'(r.flag));
               $display("result: fib=%0d overflow=%0d", fib, overflow);
            end
         end
         if (stalled_prev && term_valid) begin
            check("stall_term", int'(term), int'(prev_term));
            check("stall_idx", int'(term_idx), int'(prev_idx));
         end
         if (term_valid && out_ready) begin
            if (trm_q.size() == 0) begin
               check("unexpected_term", 1, 0);
            end else begin
               trm_t t;
               t = trm_q.pop_front();
               check("term", int'(term), int'(t.val));
               check("term_idx", int'(term_idx), int'(t.idx));
               $display("term: idx=%0d val=%0d", term_idx, term);
            end
         end
         stalled_prev = term_valid && !out_ready;
         prev_term    = term;
         prev_idx     = term_idx;
      end
   end

   // Issue a start pulse; returns at #1 after the start-sampling edge.
   task automatic start_run(input int nv, input logic md);
      start   = 1'b1;
      n_in    = NW'(nv);
      mode_in = md;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Wait for done, counting edges after the start edge and busy cycles.
   task automatic wait_done(input int limit, output int edges, output int busy_cnt);
      edges    = 0;
      busy_cnt = busy ? 1 : 0;
      while (1) begin
         @(posedge clk); #1;
         edges++;
         if (busy) busy_cnt++;
         if (done) break;
         if (edges >= limit) begin
            check("done_timeout", edges, -1);
            break;
         end
      end
   endtask

   task automatic result_run(input int nv, input int efib, input logic eovf);
      int e, b;
      res_q.push_back('{val: WIDTH'(efib), flag: eovf});
      start_run(nv, 1'b0);
      wait_done(nv + 20, e, b);
      check("done_edges", e, nv + 1);
      check("busy_cycles", b, nv + 1);
      $display("run n=%0d: done after %0d edges, busy %0d cycles", nv, e, b);
   endtask

   localparam int NR = 5;
   int tab_n[NR]    = '{10, 13, 14, 0, 1};
   int tab_fib[NR]  = '{55, 233, 121, 0, 1};
   int tab_ovf[NR]  = '{0, 0, 1, 0, 0};
   int stream5[6]   = '{0, 1, 1, 2, 3, 5};

   initial begin
      int e, b;
      // Reset state
      #12;
      check("rst_busy", int'(busy), 0);
      check("rst_term_valid", int'(term_valid), 0);
      check("rst_fib", int'(fib), 0);
      check("rst_done", int'(done), 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // abort together with start in IDLE: stays idle
      abort = 1'b1; start = 1'b1; n_in = 8'd3;
      @(posedge clk); #1;
      abort = 1'b0; start = 1'b0;
      check("abort_start_idle", int'(busy), 0);

      // Result-mode table
      for (int i = 0; i < NR; i++)
         result_run(tab_n[i], tab_fib[i], tab_ovf[i][0]);

      // Stream mode n=5 with pseudo-random out_ready
      res_q.push_back('{val: 8'd5, flag: 1'b0});
      for (int i = 0; i < 6; i++)
         trm_q.push_back('{val: WIDTH'(stream5[i]), idx: NW'(i)});
      out_ready = 1'b0;
      start_run(5, 1'b1);
      begin
         int cyc = 0;
         while (!done && cyc < 200) begin
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
            cyc++;
         end
         check("stream_finished", int'(done), 1);
      end
      out_ready = 1'b0;
      check("stream_all_terms", trm_q.size(), 0);

      // Establish a known result, then abort a long run at k=7
      result_run(13, 233, 1'b0);
      start_run(20, 1'b0);           // now after E0, k=0
      repeat (7) begin @(posedge clk); #1; end
      check("abort_k", int'(term_idx), 7);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_fib_kept", int'(fib), 233);
      check("abort_ovf_kept", int'(overflow), 0);

      // Start mid-run is ignored: run still ends at n=20 (6765 mod 256 = 109)
      res_q.push_back('{val: 8'd109, flag: 1'b1});
      start_run(20, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      start = 1'b1; n_in = 8'd3; mode_in = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(40, e, b);
      check("ignored_start_edges", e, 21 - 4);

      // Asynchronous reset mid-run at k=4
      start_run(20, 1'b0);
      repeat (4) begin @(posedge clk); #1; end
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", int'(busy), 0);
      check("arst_term", int'(term), 0);
      check("arst_idx", int'(term_idx), 0);
      check("arst_fib", int'(fib), 0);
      check("arst_ovf", int'(overflow), 0);
      check("arst_done", int'(done), 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      result_run(6, 8, 1'b0);

      // start held across done: second run takes fresh n and mode
      res_q.push_back('{val: 8'd3, flag: 1'b0});
      res_q.push_back('{val: 8'd2, flag: 1'b0});
      trm_q.push_back('{val: 8'd0, idx: 8'd0});
      trm_q.push_back('{val: 8'd1, idx: 8'd1});
      trm_q.push_back('{val: 8'd1, idx: 8'd2});
      trm_q.push_back('{val: 8'd2, idx: 8'd3});
      out_ready = 1'b1;
      start = 1'b1; n_in = 8'd4; mode_in = 1'b0;
      @(posedge clk); #1;
      begin
         int cyc = 0;
         while (!done && cyc < 50) begin @(posedge clk); #1; cyc++; end
         check("b2b_first_done", int'(done), 1);
      end
      n_in = 8'd3; mode_in = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b_busy", int'(busy), 1);
      check("b2b_mode", int'(term_valid), 1);
      wait_done(20, e, b);
      check("b2b_second_edges", e, 4);
      out_ready = 1'b0;

      repeat (3) @(posedge clk);
      check("results_drained", res_q.size(), 0);
      check("terms_drained", trm_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
